// File: rtl/uart_lcd_pkg.sv
// Shared opcodes, ASCII codes and FSM encodings for the UART-to-LCD character feeder.
package uart_lcd_pkg;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_DDRAM = 8'h80;
  localparam logic [7:0] LCD_ROW1_OFS  = 8'h40;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_FF  = 8'h0C;
  localparam logic [7:0] PRINT_MIN = 8'h20;
  localparam logic [7:0] PRINT_MAX = 8'h7E;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_FETCH = 3'd2,
    ST_ADDR  = 3'd3,
    ST_CHAR  = 3'd4,
    ST_WAIT  = 3'd5
  } state_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_MIN) && (b <= PRINT_MAX);
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// First-word-fall-through byte FIFO; a push into a full FIFO succeeds when a pop happens in the same cycle.
module uart_byte_fifo #(
  parameter int AW = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign empty     = (r_count == {(AW + 1){1'b0}});
  assign full      = (r_count == DEPTH_C);
  assign w_pop_ok  = pop & ~empty;
  assign w_push_ok = push & (~full | w_pop_ok);
  assign dout      = r_mem[r_rd_ptr];

  // Storage array, written on accepted pushes
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW + 1){1'b0}};
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_lcd_char_feeder.sv
// UART byte stream to HD44780 write requests with a 2-row cursor.
// Optional UART_LCD_OVF_CNT_EN adds the saturating ovf_cnt output.
module uart_lcd_char_feeder
  import uart_lcd_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int COLS    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_int,
  output logic       lcd_valid,
  output logic       lcd_rs,
  output logic [7:0] lcd_data,
  input  logic       lcd_ready,
  output logic       ovf
`ifdef UART_LCD_OVF_CNT_EN
  ,
  output logic [7:0] ovf_cnt
`endif
);

  localparam int          CW      = $clog2(COLS + 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS);

  logic          r_rx_int_d;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic          w_drop;
  logic [7:0]    w_fifo_dout;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_byte;
  logic          r_row;
  logic [CW-1:0] r_col;
  logic          r_pend_char;
  logic          w_row_nxt;
  logic [CW-1:0] w_col_nxt;
  logic          w_pend_nxt;

  logic          r_lcd_valid;
  logic          r_lcd_rs;
  logic [7:0]    r_lcd_data;
  logic          r_ovf;
  logic          w_issue;
  logic          w_req_rs;
  logic [7:0]    w_req_data;
  logic          w_accept;

  assign w_push   = r_rx_int_d & ~rx_int;
  assign w_drop   = w_push & w_full & ~w_pop;
  assign w_accept = r_lcd_valid & lcd_ready;

  uart_byte_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (rx_data),
    .dout  (w_fifo_dout),
    .empty (w_empty),
    .full  (w_full)
  );

  // Frame-end detection and overflow pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_int_d <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_rx_int_d <= rx_int;
      r_ovf      <= w_drop;
    end
  end

  // Next-state, cursor update and request generation; a plain character is issued
  // straight from FETCH so it reaches the bus two cycles after the FIFO goes non-empty.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_issue     = 1'b0;
    w_req_rs    = 1'b0;
    w_req_data  = 8'h00;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_pend_nxt  = r_pend_char;
    case (r_state)
      ST_INIT: begin
        w_issue     = 1'b1;
        w_req_data  = LCD_CMD_CLEAR;
        w_row_nxt   = 1'b0;
        w_col_nxt   = {CW{1'b0}};
        w_pend_nxt  = 1'b0;
        w_state_nxt = ST_WAIT;
      end
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (is_printable(r_byte)) begin
          if (r_col == COL_MAX) begin
            w_row_nxt   = ~r_row;
            w_col_nxt   = {CW{1'b0}};
            w_pend_nxt  = 1'b1;
            w_state_nxt = ST_ADDR;
          end else begin
            w_issue     = 1'b1;
            w_req_rs    = 1'b1;
            w_req_data  = r_byte;
            w_state_nxt = ST_WAIT;
          end
        end else if (r_byte == ASCII_CR) begin
          w_col_nxt   = {CW{1'b0}};
          w_state_nxt = ST_ADDR;
        end else if (r_byte == ASCII_LF) begin
          w_row_nxt   = ~r_row;
          w_col_nxt   = {CW{1'b0}};
          w_state_nxt = ST_ADDR;
        end else if (r_byte == ASCII_FF) begin
          w_issue     = 1'b1;
          w_req_data  = LCD_CMD_CLEAR;
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ADDR: begin
        w_issue     = 1'b1;
        w_req_data  = LCD_CMD_DDRAM | (r_row ? LCD_ROW1_OFS : 8'h00) | 8'(r_col);
        w_state_nxt = ST_WAIT;
      end
      ST_CHAR: begin
        w_issue     = 1'b1;
        w_req_rs    = 1'b1;
        w_req_data  = r_byte;
        w_pend_nxt  = 1'b0;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_accept) begin
          if (r_lcd_rs) begin
            w_col_nxt = (r_col == COL_MAX) ? r_col : r_col + CW'(1);
          end else if (r_lcd_data == LCD_CMD_CLEAR) begin
            w_row_nxt = 1'b0;
            w_col_nxt = {CW{1'b0}};
          end else begin
            w_col_nxt = r_col;
          end
          w_state_nxt = r_pend_char ? ST_CHAR : ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  // FSM state, latched byte and cursor
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_byte      <= 8'h00;
      r_row       <= 1'b0;
      r_col       <= {CW{1'b0}};
      r_pend_char <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_row       <= w_row_nxt;
      r_col       <= w_col_nxt;
      r_pend_char <= w_pend_nxt;
      if (w_pop) r_byte <= w_fifo_dout;
    end
  end

  // Request registers: loaded on issue, valid cleared by the accepting cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lcd_valid <= 1'b0;
      r_lcd_rs    <= 1'b0;
      r_lcd_data  <= 8'h00;
    end else if (w_issue) begin
      r_lcd_valid <= 1'b1;
      r_lcd_rs    <= w_req_rs;
      r_lcd_data  <= w_req_data;
    end else if (w_accept) begin
      r_lcd_valid <= 1'b0;
    end
  end

`ifdef UART_LCD_OVF_CNT_EN
  logic [7:0] r_ovf_cnt;

  // Saturating count of dropped bytes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_cnt <= 8'h00;
    end else if (w_drop && (r_ovf_cnt != 8'hFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 8'h01;
    end
  end

  assign ovf_cnt = r_ovf_cnt;
`endif

  assign lcd_valid = r_lcd_valid;
  assign lcd_rs    = r_lcd_rs;
  assign lcd_data  = r_lcd_data;
  assign ovf       = r_ovf;

endmodule
